write_arbiter: RTL and testbench
================================

# write_arbiter

Write-path arbiter for the two-master / two-slave AXI interconnect. It grants one write transaction at a time to M0 or M1 and decodes the granted AWADDR to S0, S1 or the default slave. It then tracks that transaction through the address, data and response phases. Its outputs, write state and AWID-routing control, drive the write-response channel stage directly downstream, which steers BVALID/BID/BRESP/BREADY based on them.

## Interface
Parameters:
- ADDR_W, 32, address width.
- S0_BASE, 32'h0000_0000, S0 region base.
- S1_BASE, 32'h0001_0000, S1 region base.
- REGION_LOG2, 16, region size as log2 bytes. A region matches when AWADDR[ADDR_W-1:REGION_LOG2] == BASE[ADDR_W-1:REGION_LOG2].

Ports:
- ACLK  in  1  clock; all state on rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- AWVALID_M0, AWVALID_M1  in  1  address-valid from each master.
- AWADDR_M0, AWADDR_M1  in  ADDR_W  write address from each master.
- WVALID_M0, WVALID_M1, WLAST_M0, WLAST_M1  in  1  write-data valid/last.
- BREADY_M0, BREADY_M1  in  1  response ready from masters.
- AWREADY_S0, AWREADY_S1, AWREADY_SD  in  1  address ready from S0, S1 and the default slave.
- WREADY_S0, WREADY_S1, WREADY_SD  in  1  data ready from S0, S1 and the default slave.
- BVALID_S0, BVALID_S1  in  1  response valid. Default-slave responses arrive on the S0 B lines.
- Arbiter_Write_State_control  out  2  00 IDLE, 01 ADDR, 10 DATA, 11 RESP.
- Arbiter_AWID_control  out  4  bits {master, default, S1, S0}:
  - 0001 M0→S0, 0010 M0→S1, 0100 M0→default
  - 1001 M1→S0, 1010 M1→S1, 1100 M1→default
  - 0000 no grant

## Operation
- FSM with states IDLE, ADDR, DATA, RESP. The state register drives Arbiter_Write_State_control directly.
- IDLE:
  - If either AWVALID is high, select the grantee.
    - Both requesting: the grantee is the master not granted last (round-robin).
    - One requesting: that master.
  - Decode the grantee's AWADDR: S0 match → S0; else S1 match → S1; else default.
  - Register the control code and go to ADDR.
  - With no request, stay in IDLE with control 0000.
- ADDR: on AWVALID_Mg && AWREADY_(selected slave), go to DATA.
- DATA:
  - A beat counts on WVALID_Mg && WREADY_(selected).
  - A beat with WLAST_Mg high goes to RESP.
  - W handshakes are ignored outside DATA. A WLAST in the same cycle as the AW handshake does not skip DATA.
- RESP:
  - On BREADY_Mg && BVALID_(S1 if S1 selected, else S0), go to IDLE.
  - Update last-grant to the current master.
  - Clear control to 0000.
- Control is latched once, at the IDLE→ADDR transition, and holds constant through ADDR, DATA and RESP. AWADDR changes after the grant have no effect.
- A request from the non-granted master is held off; it is not recorded and is re-evaluated in the next IDLE.
- Beat counter: 8 bits, internal, cleared on entry to DATA. It saturates at 255; this is diagnostic only and does not affect transitions.

## Timing
- Reset (asynchronous, any state):
  - State IDLE (00), control 0000, beat counter 0.
  - Last-grant is set to M1, so M0 wins the first contention.
  - Reset mid-transaction abandons the transaction with no completion.
- Grant latency: AWVALID sampled high in IDLE at edge N → state 01 with valid control after edge N.
- Minimum transaction is 4 cycles (IDLE, ADDR, DATA, RESP) when every handshake completes in its first cycle.
- At least one IDLE cycle separates back-to-back transactions.
- Outputs are registered only; there is no combinational path from inputs to outputs.
- A handshake stalled in any phase holds the state indefinitely; there is no timeout.

## Test plan
- Reset then M0 single-beat write:
  - AWADDR 0x0000_0010 → control 0001, states 00→01→10→11→00.
  - AWREADY_S0, WREADY_S0+WLAST and BVALID_S0+BREADY_M0 each complete on the first cycle of their phase.
- M1 write to 0x0001_0004 with 4 beats:
  - Control 1010 held for the whole transaction.
  - Stays in DATA until the 4th beat with WLAST, then RESP waits for BVALID_S1.
- M0 write to 0x0002_0000:
  - Control 0100.
  - Completes with AWREADY_SD/WREADY_SD, and BVALID_S0 in RESP.
- Both AWVALID high in back-to-back IDLE windows after reset:
  - Grants go M0, then M1, then M0.
  - Exactly one IDLE cycle between transactions.
- ARESETn low while in DATA:
  - State 00 and control 0000 immediately (asynchronous).
  - After release with both requesting, M0 is granted.
- Change AWADDR_M0 to an S1 address after the grant:
  - Control stays 0001.
  - WLAST during ADDR is ignored; the FSM still enters DATA.

Source files
------------

// File: rtl/write_arbiter.sv
// Write-path arbiter for the 2x2 AXI interconnect: grants one write
// transaction to M0 or M1, routes it to S0/S1/default, tracks AW/W/B phases.
module write_arbiter #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] S0_BASE     = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] S1_BASE     = 32'h0001_0000,
    parameter int                REGION_LOG2 = 16
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              AWVALID_M0,
    input  logic              AWVALID_M1,
    input  logic [ADDR_W-1:0] AWADDR_M0,
    input  logic [ADDR_W-1:0] AWADDR_M1,
    input  logic              WVALID_M0,
    input  logic              WVALID_M1,
    input  logic              WLAST_M0,
    input  logic              WLAST_M1,
    input  logic              BREADY_M0,
    input  logic              BREADY_M1,
    input  logic              AWREADY_S0,
    input  logic              AWREADY_S1,
    input  logic              AWREADY_SD,
    input  logic              WREADY_S0,
    input  logic              WREADY_S1,
    input  logic              WREADY_SD,
    input  logic              BVALID_S0,
    input  logic              BVALID_S1,
    output logic [1:0]        Arbiter_Write_State_control,
    output logic [3:0]        Arbiter_AWID_control
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        RESP = 2'b11
    } state_t;

    state_t      state, state_n;
    logic [3:0]  ctrl, ctrl_n;
    logic        last_grant, last_n;
    logic [7:0]  beat_cnt;

    logic              gnt;
    logic [ADDR_W-1:0] addr_g;
    logic              hit_s0, hit_s1;
    logic [2:0]        code;
    logic              gm;
    logic              aw_ok, w_ok, wlast_g, b_ok;

    // Grantee selection and address decode, used only in IDLE.
    // Round-robin only matters when both masters request together.
    always_comb begin
        gnt    = (AWVALID_M0 && AWVALID_M1) ? ~last_grant : AWVALID_M1;
        addr_g = gnt ? AWADDR_M1 : AWADDR_M0;
        // XOR then shift compares only the region-select bits.
        hit_s0 = ((addr_g ^ S0_BASE) >> REGION_LOG2) == '0;
        hit_s1 = ((addr_g ^ S1_BASE) >> REGION_LOG2) == '0;
        code   = hit_s0 ? 3'b001 : (hit_s1 ? 3'b010 : 3'b100);
    end

    // Handshake qualifiers for the latched master and slave.
    always_comb begin
        gm    = ctrl[3];
        aw_ok = (gm ? AWVALID_M1 : AWVALID_M0)
              && ((ctrl[0] && AWREADY_S0)
               || (ctrl[1] && AWREADY_S1)
               || (ctrl[2] && AWREADY_SD));
        w_ok  = (gm ? WVALID_M1 : WVALID_M0)
              && ((ctrl[0] && WREADY_S0)
               || (ctrl[1] && WREADY_S1)
               || (ctrl[2] && WREADY_SD));
        wlast_g = gm ? WLAST_M1 : WLAST_M0;
        // Default-slave responses share the S0 B lines.
        b_ok  = (gm ? BREADY_M1 : BREADY_M0)
              && (ctrl[1] ? BVALID_S1 : BVALID_S0);
    end

    // Next-state, control latch and last-grant update.
    always_comb begin
        state_n = state;
        ctrl_n  = ctrl;
        last_n  = last_grant;
        unique case (state)
            IDLE: begin
                if (AWVALID_M0 || AWVALID_M1) begin
                    ctrl_n  = {gnt, code};
                    state_n = ADDR;
                end
            end
            ADDR: begin
                if (aw_ok) state_n = DATA;
            end
            DATA: begin
                if (w_ok && wlast_g) state_n = RESP;
            end
            RESP: begin
                if (b_ok) begin
                    last_n  = gm;
                    ctrl_n  = 4'b0000;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, control and last-grant registers; M0 wins first contention.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= IDLE;
            ctrl       <= 4'b0000;
            last_grant <= 1'b1;
        end else begin
            state      <= state_n;
            ctrl       <= ctrl_n;
            last_grant <= last_n;
        end
    end

    // Diagnostic beat counter: cleared entering DATA, saturates at 255.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            beat_cnt <= 8'd0;
        end else if (state == ADDR && aw_ok) begin
            beat_cnt <= 8'd0;
        end else if (state == DATA && w_ok && beat_cnt != 8'hFF) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
    end

    assign Arbiter_Write_State_control = state;
    assign Arbiter_AWID_control        = ctrl;

endmodule

// File: tb/tb_write_arbiter.sv
// Directed self-checking bench for write_arbiter.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_write_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        AWVALID_M0, AWVALID_M1;
    logic [31:0] AWADDR_M0, AWADDR_M1;
    logic        WVALID_M0, WVALID_M1, WLAST_M0, WLAST_M1;
    logic        BREADY_M0, BREADY_M1;
    logic        AWREADY_S0, AWREADY_S1, AWREADY_SD;
    logic        WREADY_S0, WREADY_S1, WREADY_SD;
    logic        BVALID_S0, BVALID_S1;
    logic [1:0]  st;
    logic [3:0]  ctl;

    int errors = 0;
    int checks = 0;

    write_arbiter dut (
        .ACLK                        (ACLK),
        .ARESETn                     (ARESETn),
        .AWVALID_M0                  (AWVALID_M0),
        .AWVALID_M1                  (AWVALID_M1),
        .AWADDR_M0                   (AWADDR_M0),
        .AWADDR_M1                   (AWADDR_M1),
        .WVALID_M0                   (WVALID_M0),
        .WVALID_M1                   (WVALID_M1),
        .WLAST_M0                    (WLAST_M0),
        .WLAST_M1                    (WLAST_M1),
        .BREADY_M0                   (BREADY_M0),
        .BREADY_M1                   (BREADY_M1),
        .AWREADY_S0                  (AWREADY_S0),
        .AWREADY_S1                  (AWREADY_S1),
        .AWREADY_SD                  (AWREADY_SD),
        .WREADY_S0                   (WREADY_S0),
        .WREADY_S1                   (WREADY_S1),
        .WREADY_SD                   (WREADY_SD),
        .BVALID_S0                   (BVALID_S0),
        .BVALID_S1                   (BVALID_S1),
        .Arbiter_Write_State_control (st),
        .Arbiter_AWID_control        (ctl)
    );

    always #5 ACLK = ~ACLK;

    task automatic clear_all();
        AWVALID_M0 = 0; AWVALID_M1 = 0;
        WVALID_M0  = 0; WVALID_M1  = 0;
        WLAST_M0   = 0; WLAST_M1   = 0;
        BREADY_M0  = 0; BREADY_M1  = 0;
        AWREADY_S0 = 0; AWREADY_S1 = 0; AWREADY_SD = 0;
        WREADY_S0  = 0; WREADY_S1  = 0; WREADY_SD  = 0;
        BVALID_S0  = 0; BVALID_S1  = 0;
    endtask

    task automatic set_all(input logic v);
        AWVALID_M0 = v; AWVALID_M1 = v;
        WVALID_M0  = v; WVALID_M1  = v;
        WLAST_M0   = v; WLAST_M1   = v;
        BREADY_M0  = v; BREADY_M1  = v;
        AWREADY_S0 = v; AWREADY_S1 = v; AWREADY_SD = v;
        WREADY_S0  = v; WREADY_S1  = v; WREADY_SD  = v;
        BVALID_S0  = v; BVALID_S1  = v;
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [1:0] es,
                         input logic [3:0] ec);
        checks++;
        assert (st === es) else begin
            errors++;
            $error("FAIL %s state=%b expected %b", tag, st, es);
        end
        checks++;
        assert (ctl === ec) else begin
            errors++;
            $error("FAIL %s control=%b expected %b", tag, ctl, ec);
        end
    endtask

    task automatic do_reset();
        #2;
        ARESETn = 0;
        #12;
        ARESETn = 1;
        tick();
    endtask

    initial begin
        clear_all();
        AWADDR_M0 = 32'h0;
        AWADDR_M1 = 32'h0;
        ARESETn   = 0;
        #12;
        check("reset", 2'b00, 4'b0000);
        ARESETn = 1;
        tick();
        check("idle_no_req", 2'b00, 4'b0000);

        // M0 single-beat write to S0
        AWVALID_M0 = 1; AWADDR_M0 = 32'h0000_0010;
        tick(); check("m0s0_addr", 2'b01, 4'b0001);
        AWREADY_S0 = 1;
        tick(); check("m0s0_data", 2'b10, 4'b0001);
        clear_all();
        WVALID_M0 = 1; WLAST_M0 = 1; WREADY_S0 = 1;
        tick(); check("m0s0_resp", 2'b11, 4'b0001);
        clear_all();
        BVALID_S0 = 1; BREADY_M0 = 1;
        tick(); check("m0s0_done", 2'b00, 4'b0000);
        clear_all();

        // M1 4-beat write to S1
        AWVALID_M1 = 1; AWADDR_M1 = 32'h0001_0004;
        tick(); check("m1s1_addr", 2'b01, 4'b1010);
        AWADDR_M1 = 32'h0000_0000;
        AWREADY_S1 = 1;
        tick(); check("m1s1_data", 2'b10, 4'b1010);
        clear_all();
        WVALID_M1 = 1; WREADY_S1 = 1;
        tick(); check("m1s1_beat1", 2'b10, 4'b1010);
        WREADY_S1 = 0; WLAST_M1 = 1;
        tick(); check("m1s1_stall", 2'b10, 4'b1010);
        WREADY_S1 = 1; WLAST_M1 = 0;
        tick(); check("m1s1_beat2", 2'b10, 4'b1010);
        tick(); check("m1s1_beat3", 2'b10, 4'b1010);
        WLAST_M1 = 1;
        tick(); check("m1s1_beat4", 2'b11, 4'b1010);
        clear_all();
        BVALID_S0 = 1; BREADY_M1 = 1;
        tick(); check("m1s1_wrong_b", 2'b11, 4'b1010);
        BVALID_S0 = 0; BVALID_S1 = 1;
        tick(); check("m1s1_done", 2'b00, 4'b0000);
        clear_all();

        // M0 write to the default slave
        AWVALID_M0 = 1; AWADDR_M0 = 32'h0002_0000;
        tick(); check("m0sd_addr", 2'b01, 4'b0100);
        AWREADY_S0 = 1;
        tick(); check("m0sd_wrong_aw", 2'b01, 4'b0100);
        AWREADY_S0 = 0; AWREADY_SD = 1;
        tick(); check("m0sd_data", 2'b10, 4'b0100);
        clear_all();
        WVALID_M0 = 1; WLAST_M0 = 1; WREADY_SD = 1;
        tick(); check("m0sd_resp", 2'b11, 4'b0100);
        clear_all();
        BVALID_S0 = 1; BREADY_M0 = 1;
        tick(); check("m0sd_done", 2'b00, 4'b0000);
        clear_all();

        // Contention after reset, every handshake always ready
        do_reset();
        check("rr_reset_idle", 2'b00, 4'b0000);
        AWADDR_M0 = 32'h0000_0010;
        AWADDR_M1 = 32'h0001_0000;
        set_all(1'b1);
        tick(); check("rr1_addr", 2'b01, 4'b0001);
        tick(); check("rr1_data", 2'b10, 4'b0001);
        tick(); check("rr1_resp", 2'b11, 4'b0001);
        tick(); check("rr1_idle", 2'b00, 4'b0000);
        tick(); check("rr2_addr", 2'b01, 4'b1010);
        tick(); check("rr2_data", 2'b10, 4'b1010);
        tick(); check("rr2_resp", 2'b11, 4'b1010);
        tick(); check("rr2_idle", 2'b00, 4'b0000);
        tick(); check("rr3_addr", 2'b01, 4'b0001);
        tick(); check("rr3_data", 2'b10, 4'b0001);
        tick(); check("rr3_resp", 2'b11, 4'b0001);
        tick(); check("rr3_idle", 2'b00, 4'b0000);
        clear_all();

        // Last grant is now M0; take an M1 write into DATA and reset
        AWVALID_M1 = 1;
        tick(); check("rst_m1_addr", 2'b01, 4'b1010);
        AWREADY_S1 = 1;
        tick(); check("rst_m1_data", 2'b10, 4'b1010);
        clear_all();
        #2;
        ARESETn = 0;
        #1;
        check("async_reset", 2'b00, 4'b0000);
        AWVALID_M0 = 1; AWVALID_M1 = 1;
        #10;
        check("reset_held", 2'b00, 4'b0000);
        ARESETn = 1;
        tick(); check("post_rst_grant", 2'b01, 4'b0001);

        // Address change and early WLAST during ADDR
        AWADDR_M0 = 32'h0001_0000;
        WVALID_M0 = 1; WLAST_M0 = 1; WREADY_S0 = 1;
        tick(); check("hold_ctrl_addr", 2'b01, 4'b0001);
        AWREADY_S0 = 1;
        tick(); check("wlast_no_skip", 2'b10, 4'b0001);
        AWVALID_M0 = 0; AWVALID_M1 = 0; AWREADY_S0 = 0;
        tick(); check("hold_ctrl_resp", 2'b11, 4'b0001);
        clear_all();
        BVALID_S0 = 1; BREADY_M0 = 1;
        tick(); check("final_done", 2'b00, 4'b0000);
        clear_all();
        tick(); check("final_idle", 2'b00, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
